// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wr_arbiter                                         |
// | Description : Round-robin write-port arbiter driving a register bank's   |
// |               one-hot select, write enable and write data.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREGS-1:0]     chosen,
  output logic                 w_en,
  output logic [DW-1:0]        w_data,
  output logic                 err,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [NREGS-1:0] r_chosen;
  logic             r_w_en;
  logic [DW-1:0]    r_w_data;
  logic             r_err;

  logic [AW-1:0]    w_addr_arr [NREQ];
  logic [DW-1:0]    w_data_arr [NREQ];
  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [PW-1:0]    w_winner;
  logic [PW-1:0]    w_idx;
  logic [AW-1:0]    w_win_addr;
  logic             w_addr_ok;
  logic [PW-1:0]    w_ptr_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
      assign w_data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // A requester granted last edge may still hold req this cycle; mask it.
  assign w_elig = req & ~r_gnt;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_addr = w_addr_arr[w_winner];
  assign w_addr_ok  = (32'(w_win_addr) < NREGS);
  assign w_ptr_next = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_chosen <= '0;
      r_w_en   <= 1'b0;
      r_w_data <= '0;
      r_err    <= 1'b0;
    end else if (!stall && w_found) begin
      r_gnt    <= NREQ'(1) << w_winner;
      r_ptr    <= w_ptr_next;
      r_w_data <= w_data_arr[w_winner];
      if (w_addr_ok) begin
        r_chosen <= NREGS'(1) << w_win_addr;
        r_w_en   <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_chosen <= '0;
        r_w_en   <= 1'b0;
        r_err    <= 1'b1;
      end
    end else begin
      r_gnt    <= '0;
      r_chosen <= '0;
      r_w_en   <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign gnt    = r_gnt;
  assign chosen = r_chosen;
  assign w_en   = r_w_en;
  assign w_data = r_w_data;
  assign err    = r_err;
  assign busy   = |req;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_wr_arbiter                                      |
// | Description : Randomized self-checking bench with a behavioural model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 6;
  localparam int AW    = 3;
  localparam int DW    = 5;
  localparam int NCYC  = 600;

  logic                clk;
  logic                rst;
  logic                stall;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic [NREGS-1:0]    chosen;
  logic                w_en;
  logic [DW-1:0]       w_data;
  logic                err;
  logic                busy;

  int n_checks;
  int n_fail;

  // Model: each requester owns at most one pending write.
  bit              pend   [NREQ];
  logic [AW-1:0]   m_addr [NREQ];
  logic [DW-1:0]   m_data [NREQ];
  int              m_ptr;
  logic [NREQ-1:0]  exp_gnt;
  logic [NREGS-1:0] exp_chosen;
  logic             exp_wen;
  logic [DW-1:0]    exp_wdata;
  logic             exp_err;

  regfile_wr_arbiter #(
    .NREQ (NREQ),
    .NREGS(NREGS),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .req     (req),
    .req_addr(req_addr),
    .req_data(req_data),
    .gnt     (gnt),
    .chosen  (chosen),
    .w_en    (w_en),
    .w_data  (w_data),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req[i]              = pend[i];
      req_addr[i*AW +: AW] = m_addr[i];
      req_data[i*DW +: DW] = m_data[i];
    end
  endtask

  task automatic check_outputs(input string phase);
    check_eq({phase, ".gnt"},    32'(gnt),    32'(exp_gnt));
    check_eq({phase, ".chosen"}, 32'(chosen), 32'(exp_chosen));
    check_eq({phase, ".w_en"},   32'(w_en),   32'(exp_wen));
    check_eq({phase, ".w_data"}, 32'(w_data), 32'(exp_wdata));
    check_eq({phase, ".err"},    32'(err),    32'(exp_err));
  endtask

  // Predict the registered outputs after the coming edge from current inputs.
  task automatic predict();
    logic [NREQ-1:0] elig;
    int              win;
    if (rst) begin
      exp_gnt = '0; exp_chosen = '0; exp_wen = 1'b0; exp_wdata = '0; exp_err = 1'b0;
      m_ptr = 0;
      return;
    end
    elig = req & ~exp_gnt;
    win  = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && elig[idx]) win = idx;
    end
    if (stall || win < 0) begin
      exp_gnt = '0; exp_chosen = '0; exp_wen = 1'b0; exp_err = 1'b0;
    end else begin
      exp_gnt   = '0;
      exp_gnt[win] = 1'b1;
      m_ptr     = (win + 1) % NREQ;
      exp_wdata = m_data[win];
      exp_chosen = '0;
      if (int'(m_addr[win]) < NREGS) begin
        exp_chosen[m_addr[win]] = 1'b1;
        exp_wen = 1'b1;
        exp_err = 1'b0;
      end else begin
        exp_wen = 1'b0;
        exp_err = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]   = 1'b1;
      m_addr[i] = AW'(i + 1);
      m_data[i] = DW'(5'h10 + i);
    end
    drive_reqs();
    exp_gnt = '0; exp_chosen = '0; exp_wen = 1'b0; exp_wdata = '0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    predict();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int density;
      int stall_rate;
      @(negedge clk);
      check_outputs("run");

      // A requester retires its write on seeing gnt; it may start a new one at once.
      for (int i = 0; i < NREQ; i++)
        if (exp_gnt[i]) pend[i] = 1'b0;

      density    = (cyc < 100) ? 1 : ((cyc < 350) ? 3 : 6);
      stall_rate = (cyc < 100) ? 0 : ((cyc < 350) ? 6 : 3);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(density - 1, 0) == 0)) begin
          pend[i]   = 1'b1;
          m_addr[i] = AW'($urandom_range(2**AW - 1, 0));
          m_data[i] = DW'($urandom);
        end
      end
      stall = (stall_rate != 0) && ($urandom_range(stall_rate - 1, 0) == 0);
      rst   = (cyc > 100) && ($urandom_range(39, 0) == 0);
      drive_reqs();
      #1;
      check_eq("busy", 32'(busy), 32'(|req));
      predict();
    end

    @(negedge clk);
    check_outputs("final");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
